// File: rtl/pueo_pps_counter_bank.sv
// pueo_pps_counter_bank
// PPS-synchronised bank of event counters. Each PPS latches every channel's
// count into a short per-channel history and optionally clears the count.
// A seconds counter advances on each PPS. Single-cycle read port.
// Optional external-PPS holdoff is built only when PUEO_PPS_HOLDOFF_EN is defined.
`timescale 1ns/1ps
module pueo_pps_counter_bank #(
  parameter int unsigned      NCHAN         = 4,
  parameter int unsigned      CNT_WIDTH     = 32,
  parameter int unsigned      HIST_DEPTH    = 2,
  parameter int unsigned      HOLDOFF_SHIFT = 12,
  parameter int               SATURATE      = 0,
  parameter logic [NCHAN-1:0] CLEAR_MASK    = {NCHAN{1'b1}},
  localparam int unsigned     CHAN_W        = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int unsigned     IDX_W         = $clog2(HIST_DEPTH + 1)
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rstn_i,
  input  logic                       pps_i,
  input  logic                       int_pps_i,
  input  logic                       use_ext_pps_i,
  input  logic [15:0]                holdoff_i,
  input  logic                       runrst_i,
  input  logic [NCHAN-1:0]           cnt_ce_i,
  input  logic                       load_sec_i,
  input  logic [31:0]                sec_i,
  input  logic                       rd_req_i,
  input  logic [CHAN_W-1:0]          rd_chan_i,
  input  logic [IDX_W-1:0]           rd_idx_i,
  output logic                       rd_valid_o,
  output logic [CNT_WIDTH-1:0]       rd_data_o,
  output logic                       pps_flag_o,
  output logic                       pps_holdoff_o,
  output logic [31:0]                cur_sec_o,
  output logic [NCHAN*CNT_WIDTH-1:0] cur_cnt_o
);

  // Counter increment: holds at all-ones when saturating, otherwise wraps.
  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
    if ((SATURATE != 0) && (v == '1)) return v;
    return v + CNT_WIDTH'(1);
  endfunction

  logic pps_meta_p0, pps_sync_p1, pps_sync_p2, pps_edge_p2;
  logic in_holdoff;
  logic ext_flag;

  // Stage p0/p1: two-flop synchroniser; stage p2: registered rising-edge detect.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      pps_meta_p0 <= 1'b0;
      pps_sync_p1 <= 1'b0;
      pps_sync_p2 <= 1'b0;
      pps_edge_p2 <= 1'b0;
    end else begin
      pps_meta_p0 <= pps_i;
      pps_sync_p1 <= pps_meta_p0;
      pps_sync_p2 <= pps_sync_p1;
      pps_edge_p2 <= pps_sync_p1 & ~pps_sync_p2;
    end
  end

  assign ext_flag = pps_edge_p2 & ~in_holdoff;

  // Stage p3: one-cycle PPS pulse from the selected source.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) pps_flag_o <= 1'b0;
    else             pps_flag_o <= use_ext_pps_i ? ext_flag : int_pps_i;
  end

`ifdef PUEO_PPS_HOLDOFF_EN
  localparam int unsigned HO_W = 17 + HOLDOFF_SHIFT;
  logic [HO_W-1:0] hold_cnt;
  logic [HO_W-1:0] hold_load;

  // Load value L so that the holdoff window spans (holdoff_i+1)*2^SHIFT cycles.
  assign hold_load = ((HO_W'(holdoff_i) + HO_W'(1)) << HOLDOFF_SHIFT) - HO_W'(1);

  // Holdoff window: armed after each external flag, counts down to zero, then releases.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      in_holdoff <= 1'b0;
      hold_cnt   <= '0;
    end else if (!use_ext_pps_i) begin
      in_holdoff <= 1'b0;
      hold_cnt   <= '0;
    end else if (pps_flag_o) begin
      in_holdoff <= 1'b1;
      hold_cnt   <= hold_load;
    end else if (in_holdoff) begin
      if (hold_cnt == '0) in_holdoff <= 1'b0;
      else                hold_cnt   <= hold_cnt - HO_W'(1);
    end
  end
`else
  logic unused_holdoff;
  assign unused_holdoff = ^holdoff_i;
  assign in_holdoff     = 1'b0;
`endif

  assign pps_holdoff_o = in_holdoff;

  logic [CNT_WIDTH-1:0] cnt_q  [NCHAN];
  logic [CNT_WIDTH-1:0] hist_q [NCHAN][HIST_DEPTH];

  // Channel counters: run reset beats PPS clear, which beats normal counting.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      for (int c = 0; c < NCHAN; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (runrst_i)                        cnt_q[c] <= '0;
        else if (pps_flag_o && CLEAR_MASK[c]) cnt_q[c] <= cnt_ce_i[c] ? CNT_WIDTH'(1) : '0;
        else if (cnt_ce_i[c])                cnt_q[c] <= cnt_inc(cnt_q[c]);
      end
    end
  end

  // History shift on PPS: newest entry is the count before this cycle's update.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      for (int c = 0; c < NCHAN; c++)
        for (int k = 0; k < HIST_DEPTH; k++) hist_q[c][k] <= '0;
    end else if (pps_flag_o) begin
      for (int c = 0; c < NCHAN; c++) begin
        hist_q[c][0] <= cnt_q[c];
        for (int k = 1; k < HIST_DEPTH; k++) hist_q[c][k] <= hist_q[c][k-1];
      end
    end
  end

  genvar gc;
  generate
    for (gc = 0; gc < NCHAN; gc++) begin : g_cur
      assign cur_cnt_o[gc*CNT_WIDTH +: CNT_WIDTH] = cnt_q[gc];
    end
  endgenerate

  // Seconds counter: an explicit load wins over the PPS increment.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i)     cur_sec_o <= '0;
    else if (load_sec_i) cur_sec_o <= sec_i;
    else if (pps_flag_o) cur_sec_o <= cur_sec_o + 32'd1;
  end

  logic [CNT_WIDTH-1:0] rd_sel;

  // Read mux: unmatched channel or index selects zero.
  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (CHAN_W'(c) == rd_chan_i) begin
        if (rd_idx_i == '0) rd_sel = cnt_q[c];
        for (int k = 0; k < HIST_DEPTH; k++)
          if (rd_idx_i == IDX_W'(k + 1)) rd_sel = hist_q[c][k];
      end
    end
  end

  // Read response: one-cycle valid, data held until the next request.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= rd_sel;
    end
  end

endmodule
